// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single register-file write port between
// requester A (execute result) and requester B (load result). Round-robin on
// conflict, one registered write per cycle, saturating conflict counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// LAST_A  | A was granted most recently; B wins the next conflict
// LAST_B  | B was granted most recently (also the reset state); A wins next
module wb_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_src,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_t;

  last_t             last_q;
  last_t             last_d;
  logic              grant_a;
  logic              grant_b;
  logic              granted;
  logic              conflict;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Round-robin state register; B is "last" out of reset so A wins first.
  always_ff @(posedge clk) begin
    if (rst) last_q <= LAST_B;
    else     last_q <= last_d;
  end

  // Grant decision, next round-robin state and winning address/data select.
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    last_d   = last_q;
    sel_addr = a_addr;
    sel_data = a_data;
    conflict = a_valid && b_valid && !wr_stall && !rst;
    if (!rst && !wr_stall) begin
      if (a_valid && b_valid) begin
        if (last_q == LAST_B) grant_a = 1'b1;
        else                  grant_b = 1'b1;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
    if (grant_b) begin
      last_d   = LAST_B;
      sel_addr = b_addr;
      sel_data = b_data;
    end else if (grant_a) begin
      last_d = LAST_A;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign granted = grant_a || grant_b;

  // Registered write port; x0 writes are consumed but never strobe the file,
  // and leave the held address/data untouched so only wr_src moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_src  <= 1'b0;
    end else begin
      wr_en <= granted && (sel_addr != '0);
      if (granted) begin
        wr_src <= grant_b;
        if (sel_addr != '0) begin
          wr_addr <= sel_addr;
          wr_data <= sel_data;
        end
      end
    end
  end

  // Conflict counter saturates at all-ones for performance debug.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed sequences then random traffic.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, wr_stall;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        wr_en, wr_src;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  conflict_cnt;

  logic        s_a_ready, s_b_ready, s_wr_en, s_wr_src;
  logic [4:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [1:0]  s_conflict_cnt;

  always #5 clk = ~clk;

  wb_port_arbiter #(.ADDR_W(5), .DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_src(wr_src), .conflict_cnt(conflict_cnt)
  );

  wb_port_arbiter #(.ADDR_W(5), .DATA_W(32), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(s_a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(s_b_ready),
    .wr_stall(wr_stall), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .wr_src(s_wr_src), .conflict_cnt(s_conflict_cnt)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        src;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference state: what the write port should show after the last edge.
  logic        m_ok = 1'b0;
  logic        m_en, m_src, m_last;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_conf;
  logic        acc_a = 1'b0, acc_b = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: checks the previous edge's results, then predicts this cycle.
  always @(negedge clk) begin
    logic ga, gb, w;
    logic [4:0] ad;
    if (m_ok) begin
      chk("wr_en", wr_en, m_en);
      chk("wr_src", wr_src, m_src);
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_data", wr_data, m_data);
      chk("conflict_cnt", conflict_cnt, (m_conf > 255) ? 255 : m_conf);
      chk("sat_conflict_cnt", s_conflict_cnt, (m_conf > 3) ? 3 : m_conf);
      chk("sat_wr_en", s_wr_en, m_en);
      chk("sat_wr_src", s_wr_src, m_src);
    end
    ga = 1'b0;
    gb = 1'b0;
    if (rst !== 1'b1 && wr_stall !== 1'b1 && m_ok) begin
      if (a_valid && b_valid) begin
        if (m_last) ga = 1'b1; else gb = 1'b1;
      end else begin
        ga = a_valid;
        gb = b_valid;
      end
    end
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    chk("sat_a_ready", s_a_ready, ga);
    chk("sat_b_ready", s_b_ready, gb);
    acc_a = ga;
    acc_b = gb;
    if (rst) begin
      m_ok   = 1'b1;
      m_en   = 1'b0;
      m_src  = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_conf = 0;
      m_last = 1'b1;
    end else begin
      m_en = 1'b0;
      if (ga || gb) begin
        w      = gb;
        ad     = w ? b_addr : a_addr;
        m_last = w;
        m_src  = w;
        if (ad != 5'd0) begin
          m_en   = 1'b1;
          m_addr = ad;
          m_data = w ? b_data : a_data;
          exp_q.push_back('{addr: ad, data: m_data, src: w});
        end
      end
      if (a_valid && b_valid && !wr_stall) m_conf++;
    end
  end

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    wr_t e;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h with no write expected", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_addr", wr_addr, e.addr);
        chk("sb_data", wr_data, e.data);
        chk("sb_src", wr_src, e.src);
      end
    end
  end

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic st, input logic r);
    @(posedge clk);
    #1;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    wr_stall = st; rst = r;
  endtask

  initial begin
    rst = 1'b1; wr_stall = 1'b0;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hAAAA_0003;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hBBBB_0007;
    @(posedge clk);
    // second reset cycle, then round-robin conflict for 4 cycles
    drive(1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_0007, 0, 1);
    repeat (4) drive(1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_0007, 0, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    drive(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, 0, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    drive(0, 5'd0, 32'h0, 1, 5'd0, 32'h0000_1234, 0, 0);
    drive(1, 5'd9, 32'h9999_0009, 0, 5'd0, 32'h0, 0, 0);
    repeat (3) drive(1, 5'd4, 32'h4444_0004, 1, 5'd6, 32'h6666_0006, 1, 0);
    repeat (2) drive(1, 5'd4, 32'h4444_0004, 1, 5'd6, 32'h6666_0006, 0, 0);
    repeat (2) drive(1, 5'd12, 32'h1212_000A, 1, 5'd12, 32'h1212_000B, 0, 0);
    drive(1, 5'd2, 32'h2222_0002, 1, 5'd8, 32'h8888_0008, 0, 1);
    drive(1, 5'd2, 32'h2222_0002, 1, 5'd8, 32'h8888_0008, 0, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);

    // Random traffic: requesters hold until accepted; rare resets late in the run.
    for (int c = 0; c < 3000; c++) begin
      logic av, bv, st, r;
      logic [4:0] aa, ba;
      logic [31:0] ad, bd;
      av = a_valid; aa = a_addr; ad = a_data;
      bv = b_valid; ba = b_addr; bd = b_data;
      if (!a_valid || acc_a) begin
        av = ($urandom_range(0, 3) != 0);
        aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        ad = $urandom;
      end
      if (!b_valid || acc_b) begin
        bv = ($urandom_range(0, 3) != 0);
        ba = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        bd = $urandom;
      end
      st = ($urandom_range(0, 7) == 0);
      r  = (c > 2000) && ($urandom_range(0, 49) == 0);
      drive(av, aa, ad, bv, ba, bd, st, r);
    end
    repeat (3) drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two writeback requesters: A (ALU/execute result) and B (load/memory result).
- Each requester presents a 5-bit destination register address and 32-bit data with a valid/ready handshake.
- The block grants one requester per cycle using round-robin on conflict, and registers the winning address and data onto the write port.
- It drives the select of the downstream 5-bit address mux and the data mux (wr_src), and keeps a saturating conflict counter for performance debug.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, write data width.
- CNT_W, 8, conflict counter width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A has a write pending.
- a_addr  input  ADDR_W  requester A destination register.
- a_data  input  DATA_W  requester A write data.
- a_ready  output  1  A accepted this cycle (combinational).
- b_valid  input  1  requester B has a write pending.
- b_addr  input  ADDR_W  requester B destination register.
- b_data  input  DATA_W  requester B write data.
- b_ready  output  1  B accepted this cycle (combinational).
- wr_stall  input  1  write port unavailable; blocks all grants.
- wr_en  output  1  registered write strobe to register file.
- wr_addr  output  ADDR_W  registered write address.
- wr_data  output  DATA_W  registered write data.
- wr_src  output  1  registered source of last accepted write (0=A, 1=B); drives the mux selector.
- conflict_cnt  output  CNT_W  saturating count of cycles where A and B were both valid.

Behaviour:
- Reset (rst=1 at a clock edge): wr_en=0, wr_addr=0, wr_data=0, wr_src=0, conflict_cnt=0, last_grant=B (so A wins the first conflict).
- While rst=1, a_ready=b_ready=0.
- Grant logic, all combinational from the current inputs and last_grant:
  - wr_stall=1 or rst=1: no grant.
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester that is not last_grant.
  - a_ready = grant_A; b_ready = grant_B. At most one ready is high per cycle.
  - Handshake is complete when valid && ready.
- Requesters must hold valid/addr/data stable until accepted; the arbiter never drops a valid request.
- last_grant updates to the granted requester on every grant, whether or not a conflict occurred.
- Latency: an acceptance at edge N produces wr_en=1 with that addr/data/src visible after edge N (one cycle); throughput is one write per cycle.
- wr_en is a single-cycle pulse per acceptance. With no acceptance in a cycle, wr_en=0 and wr_addr/wr_data/wr_src hold their last values.
- x0 rule: a request with addr=0 is accepted normally (ready asserted, last_grant updated) but produces wr_en=0. wr_addr/wr_data are not updated; wr_src is updated.
- conflict_cnt increments by 1 each cycle where a_valid && b_valid && !wr_stall && !rst. It saturates at 2^CNT_W-1 and does not wrap.
- Same destination from both requesters in the same cycle: no merging. Both writes occur in grant order (round-robin), and the later one wins in the register file.
- wr_stall asserted mid-stream: no grants, wr_en=0 next cycle, and pending requests wait. last_grant and conflict_cnt are unchanged.
- Reset mid-operation: any in-flight request is not accepted. Outputs clear at the next edge, and requesters re-present after reset deasserts.

Test Plan:
- Reset: hold rst 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, wr_en=0, all outputs 0. Release -> first grant goes to A.
- Single requester: A presents addr=5, data=0xDEADBEEF for 1 cycle -> a_ready=1 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, wr_src=0.
- Conflict round-robin: A and B both continuously valid (A addr=3, B addr=7) for 4 cycles -> grants A,B,A,B; wr_src sequence 0,1,0,1; conflict_cnt=4.
- x0 write: B presents addr=0, data=0x1234 -> b_ready=1; next cycle wr_en=0, wr_addr/wr_data unchanged, wr_src=1. A following A request with addr=9 writes normally.
- Stall: both valid, wr_stall=1 for 3 cycles -> no ready, wr_en=0, conflict_cnt unchanged. Release -> grant order resumes from the preserved last_grant.
- Saturation: with CNT_W=2, hold both valid for 6 cycles -> conflict_cnt reaches 3 and stays 3.
